// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: widths, FSM states,
// datapath select codes, instruction classes and the opcode set it accepts.
package mc_ctrl_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int OP_WIDTH    = 6;
    localparam int FUNCT_WIDTH = 6;

    // Control FSM states; values are visible on the debug state port
    typedef enum logic [2:0] {
        MC_FETCH  = 3'd0,
        MC_DECODE = 3'd1,
        MC_EXEC   = 3'd2,
        MC_MEM    = 3'd3,
        MC_WB     = 3'd4,
        MC_HALT   = 3'd5
    } mc_state_e;

    // Decoder instruction class
    localparam logic [1:0] R_TYPE = 2'd0;
    localparam logic [1:0] I_TYPE = 2'd1;
    localparam logic [1:0] J_TYPE = 2'd2;

    // PC source select
    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    // Write-back data select
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    // Destination register select
    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_JR = 6'b001000;

    // Supported opcodes (MIPS-style); OP_ERR is what the decoder emits for garbage
    localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_WIDTH-1:0] OP_J     = 6'b000010;
    localparam logic [OP_WIDTH-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_WIDTH-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_WIDTH-1:0] OP_BLEZ  = 6'b000110;
    localparam logic [OP_WIDTH-1:0] OP_BGTZ  = 6'b000111;
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_WIDTH-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_WIDTH-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_WIDTH-1:0] OP_SLTIU = 6'b001011;
    localparam logic [OP_WIDTH-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_WIDTH-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_WIDTH-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_WIDTH-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_WIDTH-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_WIDTH-1:0] OP_LH    = 6'b100001;
    localparam logic [OP_WIDTH-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_WIDTH-1:0] OP_LBU   = 6'b100100;
    localparam logic [OP_WIDTH-1:0] OP_LHU   = 6'b100101;
    localparam logic [OP_WIDTH-1:0] OP_SB    = 6'b101000;
    localparam logic [OP_WIDTH-1:0] OP_SH    = 6'b101001;
    localparam logic [OP_WIDTH-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_WIDTH-1:0] OP_ERR   = 6'b111111;

endpackage

// File: rtl/mc_ctrl_if.sv
// Instruction/data memory req/ack handshake between the control unit
// (master) and the memories (slave). dmem_we qualifies dmem_req as a store.
interface mc_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/mc_ctrl_op_class.sv
// Combinational instruction classifier: turns decoder opcode/funct/type into
// the handful of class flags the control FSM branches on.
module mc_op_class
    import mc_ctrl_pkg::*;
(
    input  logic [1:0]             inst_type,
    input  logic [OP_WIDTH-1:0]    op_code,
    input  logic [FUNCT_WIDTH-1:0] funct,
    output logic                   is_load,
    output logic                   is_store,
    output logic                   is_branch,
    output logic                   is_j,
    output logic                   is_jal,
    output logic                   is_jr,
    output logic                   legal
);

    // Opcode lookup; anything not listed (OP_ERR included) is illegal
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_j      = 1'b0;
        is_jal    = 1'b0;
        is_jr     = 1'b0;
        legal     = 1'b0;
        case (op_code)
            OP_RTYPE: begin
                legal = 1'b1;
                is_jr = (inst_type == R_TYPE) && (funct == FUNCT_JR);
            end
            OP_J: begin
                legal = 1'b1;
                is_j  = 1'b1;
            end
            OP_JAL: begin
                legal  = 1'b1;
                is_jal = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                legal     = 1'b1;
                is_branch = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                legal = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                legal   = 1'b1;
                is_load = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                legal    = 1'b1;
                is_store = 1'b1;
            end
            OP_ERR: begin
                legal = 1'b0;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Outputs are decoded combinationally from the state plus the instruction
// class, and are all forced idle while rst (active-low, async) is held.
// Optional feature: define MC_INSTRET_EN to add the W-bit instret counter
// of retired instructions.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int W = WORD_WIDTH
)
(
    input  logic                   clk,
    input  logic                   rst,
    mc_ctrl_if.master              mem,
    input  logic [1:0]             inst_type,
    input  logic [OP_WIDTH-1:0]    op_code,
    input  logic [FUNCT_WIDTH-1:0] funct,
    input  logic                   branch_taken,
    output logic                   ir_we,
    output logic                   pc_we,
    output logic [1:0]             pc_src,
    output logic                   alu_src_imm,
    output logic                   reg_we,
    output logic [1:0]             wb_sel,
    output logic [1:0]             reg_dst,
    output logic                   illegal,
    output logic [2:0]             state
`ifdef MC_INSTRET_EN
    ,
    output logic [W-1:0]           instret
`endif
);

    mc_state_e state_r;
    mc_state_e next_s;
    logic      illegal_r;
    logic      retire_s;
    logic      imem_req_s;
    logic      dmem_req_s;
    logic      dmem_we_s;
    logic      is_load_s;
    logic      is_store_s;
    logic      is_branch_s;
    logic      is_j_s;
    logic      is_jal_s;
    logic      is_jr_s;
    logic      legal_s;

    mc_op_class u_op_class (
        .inst_type (inst_type),
        .op_code   (op_code),
        .funct     (funct),
        .is_load   (is_load_s),
        .is_store  (is_store_s),
        .is_branch (is_branch_s),
        .is_j      (is_j_s),
        .is_jal    (is_jal_s),
        .is_jr     (is_jr_s),
        .legal     (legal_s)
    );

    // Next state, retire strobe and all datapath controls; idle while in reset
    always_comb begin
        next_s      = state_r;
        retire_s    = 1'b0;
        imem_req_s  = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_SRC_PC4;
        alu_src_imm = 1'b0;
        dmem_req_s  = 1'b0;
        dmem_we_s   = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = WB_SEL_ALU;
        reg_dst     = REG_DST_RT;
        if (!rst) begin
            next_s = MC_FETCH;
        end else begin
            case (state_r)
                MC_FETCH: begin
                    imem_req_s = 1'b1;
                    if (mem.imem_ack) begin
                        ir_we  = 1'b1;
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_PC4;
                        next_s = MC_DECODE;
                    end else begin
                        next_s = MC_FETCH;
                    end
                end
                MC_DECODE: begin
                    if (legal_s) begin
                        next_s = MC_EXEC;
                    end else begin
                        next_s = MC_HALT;
                    end
                end
                MC_EXEC: begin
                    alu_src_imm = (inst_type == I_TYPE) && !is_branch_s;
                    if (is_branch_s) begin
                        pc_we    = branch_taken;
                        pc_src   = PC_SRC_BRANCH;
                        next_s   = MC_FETCH;
                        retire_s = 1'b1;
                    end else if (is_j_s) begin
                        pc_we    = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                        next_s   = MC_FETCH;
                        retire_s = 1'b1;
                    end else if (is_jal_s) begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_JUMP;
                        next_s = MC_WB;
                    end else if (is_jr_s) begin
                        pc_we    = 1'b1;
                        pc_src   = PC_SRC_RS;
                        next_s   = MC_FETCH;
                        retire_s = 1'b1;
                    end else if (is_load_s || is_store_s) begin
                        next_s = MC_MEM;
                    end else begin
                        next_s = MC_WB;
                    end
                end
                MC_MEM: begin
                    dmem_req_s = 1'b1;
                    dmem_we_s  = is_store_s;
                    if (mem.dmem_ack) begin
                        if (is_store_s) begin
                            next_s   = MC_FETCH;
                            retire_s = 1'b1;
                        end else begin
                            next_s = MC_WB;
                        end
                    end else begin
                        next_s = MC_MEM;
                    end
                end
                MC_WB: begin
                    reg_we   = 1'b1;
                    next_s   = MC_FETCH;
                    retire_s = 1'b1;
                    if (is_jal_s) begin
                        wb_sel  = WB_SEL_LINK;
                        reg_dst = REG_DST_R31;
                    end else if (is_load_s) begin
                        wb_sel  = WB_SEL_MEM;
                        reg_dst = REG_DST_RT;
                    end else if (inst_type == R_TYPE) begin
                        wb_sel  = WB_SEL_ALU;
                        reg_dst = REG_DST_RD;
                    end else begin
                        wb_sel  = WB_SEL_ALU;
                        reg_dst = REG_DST_RT;
                    end
                end
                MC_HALT: begin
                    next_s = MC_HALT;
                end
                default: begin
                    // Corrupted state encoding: park safely until reset
                    next_s = MC_HALT;
                end
            endcase
        end
    end

    // State register, async-cleared to FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= MC_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Sticky illegal-instruction flag, set when DECODE rejects the opcode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_r <= 1'b0;
        end else if ((state_r == MC_DECODE) && !legal_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

`ifdef MC_INSTRET_EN
    logic [W-1:0] instret_r;

    // Retired-instruction counter, wraps naturally at 2^W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret = instret_r;
`else
    logic unused_retire_s;
    assign unused_retire_s = retire_s;
`endif

    assign mem.imem_req = imem_req_s;
    assign mem.dmem_req = dmem_req_s;
    assign mem.dmem_we  = dmem_we_s;
    assign illegal      = illegal_r;
    assign state        = state_r;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM that sequences the CPU datapath around the instruction decoder. Each instruction runs FETCH → DECODE → EXEC → [MEM] → [WB].
- Drives the PC, IR, register-file and memory enables/selects from the decoded op_code/funct/inst_type.
- Talks to instruction and data memory through a req/ack handshake, so variable-latency memories are supported.
- Sits between the decoder outputs and the datapath muxes/enables.

Parameters:
- W, `WORD_WIDTH, datapath word width (instret counter width).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: one clock; reset is asynchronous and active-low.
- inst_type  in  2  decoder type (`R_TYPE/`I_TYPE/`J_TYPE`); valid from DECODE onward.
- op_code  in  `OP_WIDTH  decoder opcode.
- funct  in  `FUNCT_WIDTH  decoder funct.
- branch_taken  in  1  ALU compare result; sampled in EXEC only.
- imem_ack  in  1  instruction memory ack; IR data valid this cycle.
- dmem_ack  in  1  data memory ack; load data valid / store done.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  latch instruction register.
- pc_we  out  1  PC write enable.
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump imm, 3 rs (JR).
- alu_src_imm  out  1  ALU B operand = imm.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  store qualifier of dmem_req.
- reg_we  out  1  register file write enable.
- wb_sel  out  2  0 ALU, 1 memory, 2 link (PC+4).
- reg_dst  out  2  0 rt, 1 rd, 2 r31.
- illegal  out  1  sticky illegal-instruction flag.
- state  out  3  current state (debug).

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. State register is async-cleared by rst low. All other outputs are decoded combinationally from state plus class inputs (Moore outputs, plus class-dependent selects).
- Reset:
  - While rst=0: state=FETCH, illegal=0, instret=0.
  - While rst=0: every enable/request output forced 0 (imem_req included); selects = 0.
  - Reset mid-operation drops any outstanding imem/dmem request immediately. Memories must tolerate an abandoned request.
- FETCH:
  - imem_req=1 held until imem_ack.
  - On the ack cycle: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - Ack in the same cycle as the first req is accepted (zero-wait → FETCH lasts 1 cycle).
  - Acks outside FETCH (or dmem_ack outside MEM) are ignored.
- DECODE (1 cycle):
  - Classify the instruction.
  - If op_code==`OP_ERR` or not in the supported set: set illegal, go to HALT.
  - Otherwise go to EXEC.
- EXEC (1 cycle). alu_src_imm=1 for I-type non-branch.
  - Branch: pc_we=branch_taken, pc_src=1, then FETCH.
  - J: pc_we=1, pc_src=2, then FETCH.
  - JAL: pc_we=1, pc_src=2, then WB (wb_sel=2, reg_dst=2).
  - JR (R-type, funct 6'b001000): pc_we=1, pc_src=3, then FETCH.
  - Load/store: go to MEM.
  - Other ALU: go to WB.
  - The pc_we in EXEC uses the PC already incremented in FETCH.
- MEM:
  - dmem_req=1 (dmem_we=1 for SB/SH/SW) held until dmem_ack.
  - On ack: store goes to FETCH; load goes to WB (wb_sel=1, reg_dst=0).
- WB (1 cycle):
  - reg_we=1, then FETCH.
  - reg_dst: 1 for R-type, 0 for I-type, 2 for JAL.
  - wb_sel: 0 ALU, 1 load, 2 JAL.
- HALT: sticky. All enables 0, no requests. Exit only via rst.
- Latency with zero-wait memories:
  - ALU / JAL: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch / J / JR: 3 cycles.
- Inputs are assumed stable from DECODE through the last state of the instruction (IR is not rewritten until the next FETCH ack).

Optional Feature:
- Macro MC_INSTRET_EN.
- When defined:
  - Adds output instret (W bits): count of retired instructions.
  - Increments on the final cycle of each instruction: EXEC→FETCH, MEM→FETCH (store), WB→FETCH.
  - Wraps modulo 2^W; cleared by reset.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Add to defines.v:
  - State encodings (`MC_FETCH`..`MC_HALT`).
  - pc_src encodings (`PC_SRC_*`), wb_sel encodings (`WB_SEL_*`), reg_dst encodings (`REG_DST_*`).
  - `FUNCT_JR`.
- One combinational sub-module, mc_op_class, with outputs: is_load, is_store, is_branch, is_j, is_jal, is_jr, legal, derived from op_code/funct/inst_type. The FSM lives in mc_ctrl.

Test Plan:
1. ADDU R-type, imem_ack/dmem_ack tied 1 → states 0,1,2,4,0. reg_we=1 only in cycle 4, reg_dst=1, wb_sel=0. pc_we in cycle 1.
2. LW with dmem_ack delayed 3 cycles → dmem_req=1, dmem_we=0 for 4 cycles in MEM, then WB with wb_sel=1, reg_dst=0. Total 8 cycles.
3. BEQ:
   - branch_taken=1 → pc_we=1, pc_src=1 in EXEC, then FETCH, no reg_we.
   - branch_taken=0 → pc_we=0 in EXEC.
4. JAL → EXEC pc_we=1, pc_src=2; WB reg_we=1, reg_dst=2, wb_sel=2.
5. op_code=`OP_ERR` → DECODE→HALT, illegal=1 sticky. Further imem_ack pulses cause no req/enables. Only rst=0 clears illegal and returns to FETCH.
6. Assert rst=0 mid-MEM with dmem_req=1 → dmem_req drops same cycle (async), state=0. After release: imem_req=1. With MC_INSTRET_EN, instret=0 after release.
